// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if -- start/busy/done handshake and data bus for the BCD-to-binary converter.
// Rev 1.0
`default_nettype none

interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic [OUT_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output start, bcd, input  bin, busy, done, err);
  modport slave  (input  start, bcd, output bin, busy, done, err);
endinterface

`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq -- sequential BCD-to-binary converter, one multiply-by-10-and-add step per clock.
// Rev 1.0
`default_nettype none

module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  bcd_to_bin_seq_if.slave bus_if
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [OUT_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  errflag_q, errflag_d;
  logic [OUT_W-1:0]      bin_q, bin_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [3:0]            digit;
  logic [OUT_W-1:0]      acc_x10;
  logic [OUT_W-1:0]      acc_next;
  logic                  errflag_next;

  // Most significant digit first; the x10 is built wide and then truncated to OUT_W.
  assign digit        = shadow_q[{cnt_q, 2'b00} +: 4];
  assign acc_x10      = OUT_W'(({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1));
  assign acc_next     = acc_x10 + OUT_W'(digit);
  assign errflag_next = errflag_q | (digit > 4'd9);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      errflag_q <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      errflag_q <= errflag_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    errflag_d = errflag_q;
    bin_d     = bin_q;
    err_d     = err_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          shadow_d  = bus_if.bcd;
          acc_d     = '0;
          cnt_d     = CNT_INIT;
          errflag_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        acc_d     = acc_next;
        errflag_d = errflag_next;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          // Invalid digits were still accumulated; the flag forces the published result to zero.
          bin_d   = errflag_next ? '0 : acc_next;
          err_d   = errflag_next;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_if.bin  = bin_q;
  assign bus_if.err  = err_q;
  assign bus_if.busy = busy_q;
  assign bus_if.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq -- directed self-checking bench for bcd_to_bin_seq (DIGITS=4, OUT_W=14).
// Rev 1.0
`default_nettype none

module tb_bcd_to_bin_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [13:0] prev_bin;
  logic        prev_err;

  bcd_to_bin_seq_if #(.DIGITS(4), .OUT_W(14)) u_if ();

  bcd_to_bin_seq #(.DIGITS(4), .OUT_W(14)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single conversion with full timing checks; optionally changes BCD right after the accepting edge.
  task automatic convert(input logic [15:0] b, input logic use_late, input logic [15:0] b_late,
                         input logic [13:0] exp_bin, input logic exp_err);
    u_if.bcd   = b;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    if (use_late) u_if.bcd = b_late;
    for (int i = 1; i <= 4; i++) begin
      check("busy_conv", u_if.busy, 1);
      check("done_conv", u_if.done, 0);
      check("bin_hold", u_if.bin, prev_bin);
      check("err_hold", u_if.err, prev_err);
      step();
    end
    check("done_pulse", u_if.done, 1);
    check("busy_at_done", u_if.busy, 0);
    check("bin_result", u_if.bin, exp_bin);
    check("err_result", u_if.err, exp_err);
    prev_bin = exp_bin;
    prev_err = exp_err;
    step();
    check("done_low_after", u_if.done, 0);
    check("busy_idle", u_if.busy, 0);
  endtask

  initial begin
    int dones;
    n_checks   = 0;
    n_errors   = 0;
    prev_bin   = '0;
    prev_err   = 1'b0;
    u_if.start = 1'b0;
    u_if.bcd   = '0;
    rst_n      = 1'b0;
    step();
    step();
    check("rst_bin", u_if.bin, 0);
    check("rst_busy", u_if.busy, 0);
    check("rst_done", u_if.done, 0);
    check("rst_err", u_if.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    convert(16'h1234, 1'b0, 16'h0000, 14'd1234, 1'b0);
    convert(16'h9999, 1'b0, 16'h0000, 14'd9999, 1'b0);
    convert(16'h0000, 1'b0, 16'h0000, 14'd0,    1'b0);
    convert(16'h12A4, 1'b0, 16'h0000, 14'd0,    1'b1);
    convert(16'h0007, 1'b0, 16'h0000, 14'd7,    1'b0);

    // Start held high: Done every 6 cycles, first in the 5th cycle after the accepting edge.
    u_if.bcd   = 16'h0042;
    u_if.start = 1'b1;
    dones      = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      check("b2b_done", u_if.done, ((i % 6) == 4) ? 1 : 0);
      if (u_if.done) begin
        dones++;
        check("b2b_bin", u_if.bin, 42);
      end
      if (i == 15) u_if.start = 1'b0;
    end
    check("b2b_count", dones, 3);
    prev_bin = 14'd42;
    prev_err = 1'b0;
    step();
    step();
    check("b2b_idle", u_if.busy, 0);

    // Extra Start pulse during Busy must not add a conversion.
    u_if.bcd   = 16'h0042;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    step();
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (u_if.done) dones++;
      step();
    end
    check("extra_start_dones", dones, 1);

    convert(16'h1234, 1'b1, 16'h5678, 14'd1234, 1'b0);

    // Reset asserted during the second CONV cycle of 8765.
    u_if.bcd   = 16'h8765;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    step();
    check("pre_rst_busy", u_if.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bin", u_if.bin, 0);
    check("mid_rst_busy", u_if.busy, 0);
    check("mid_rst_done", u_if.done, 0);
    check("mid_rst_err", u_if.err, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (u_if.done || u_if.busy) dones++;
    end
    check("post_rst_activity", dones, 0);
    prev_bin = '0;
    prev_err = 1'b0;
    convert(16'h0001, 1'b0, 16'h0000, 14'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
